// File: rtl/kbd_pkg.sv
// Shared scan-code constants, event layout and pop-FSM state type for the
// keyboard event controller.
package kbd_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_PAUSE = 8'hE1;

    localparam int unsigned SKIP_W = 3;
    localparam logic [SKIP_W-1:0] PAUSE_SKIP = 3'd7;

    localparam int EVT_W   = 16;
    localparam int EVT_BRK = 15;
    localparam int EVT_EXT = 14;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        WAIT
    } pop_state_t;

    function automatic logic [EVT_W-1:0] make_event(input logic       brk,
                                                    input logic       ext,
                                                    input logic [7:0] code);
        return {brk, ext, 6'b0, code};
    endfunction

endpackage

// File: rtl/kbd_evt_fifo.sv
// Show-ahead synchronous FIFO for key events; the head entry is always visible
// on rd_data (zero when empty).
module kbd_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     clrn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;

    // A pop on an empty FIFO is ignored; a push into a full FIFO only lands
    // when the same cycle frees a slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/kbd_event_ctrl.sv
// Owns the ps2_keyboard pop handshake, parses scan-code bytes into key events,
// filters typematic repeats and queues events for the CPU side.
module kbd_event_ctrl
    import kbd_pkg::*;
#(
    parameter int DEPTH           = 8,
    parameter int SUPPRESS_REPEAT = 1
) (
    input  logic                   clk,
    input  logic                   clrn,
    input  logic                   en,
    input  logic                   ps_ready,
    input  logic [7:0]             ps_data,
    input  logic                   ps_overflow,
    output logic                   ps_nextdata_n,
    output logic                   evt_valid,
    output logic [15:0]            evt_data,
    input  logic                   evt_pop,
    output logic [$clog2(DEPTH):0] evt_count,
    output logic                   evt_lost,
    output logic                   hw_ovf,
    input  logic                   clr_status
);

    pop_state_t         state_q;
    logic               nextdata_n_q;
    logic               sample;

    logic [SKIP_W-1:0]  skip_q, skip_d;
    logic               ext_q, ext_d;
    logic               rel_q, rel_d;
    logic               evt_fire;
    logic [EVT_W-1:0]   evt_word;

    logic [8:0]         held_q, held_d;
    logic               held_vld_q, held_vld_d;
    logic [8:0]         key;
    logic               key_match;
    logic               push;

    logic               lost_q, lost_d;
    logic               ovf_q, ovf_d;

    logic               fifo_full;
    logic               fifo_empty;

    // ready is looked at only in IDLE, so a stale ready during POP/WAIT can
    // never cause a second pop of the same byte.
    assign sample = (state_q == IDLE) && en && ps_ready;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q      <= IDLE;
            nextdata_n_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sample) begin
                        state_q      <= POP;
                        nextdata_n_q <= 1'b0;
                    end
                end
                POP: begin
                    state_q      <= WAIT;
                    nextdata_n_q <= 1'b1;
                end
                WAIT: begin
                    state_q      <= IDLE;
                    nextdata_n_q <= 1'b1;
                end
                default: begin
                    state_q      <= IDLE;
                    nextdata_n_q <= 1'b1;
                end
            endcase
        end
    end

    assign ps_nextdata_n = nextdata_n_q;

    // Byte parser: prefixes only touch flags; an overflow resyncs the parser
    // and swallows any byte sampled in the same cycle.
    always_comb begin
        skip_d   = skip_q;
        ext_d    = ext_q;
        rel_d    = rel_q;
        evt_fire = 1'b0;
        evt_word = '0;
        if (sample && !ps_overflow) begin
            if (skip_q != '0) begin
                skip_d = skip_q - 1'b1;
            end else if (ps_data == SC_PAUSE) begin
                skip_d = PAUSE_SKIP;
            end else if (ps_data == SC_EXT) begin
                ext_d = 1'b1;
            end else if (ps_data == SC_BREAK) begin
                rel_d = 1'b1;
            end else begin
                evt_fire = 1'b1;
                evt_word = make_event(rel_q, ext_q, ps_data);
                ext_d    = 1'b0;
                rel_d    = 1'b0;
            end
        end
        if (ps_overflow) begin
            skip_d = '0;
            ext_d  = 1'b0;
            rel_d  = 1'b0;
        end
    end

    assign key       = {evt_word[EVT_EXT], evt_word[7:0]};
    assign key_match = held_vld_q && (held_q == key);

    // Repeat filter: the held key is the last make let through; breaks always pass.
    always_comb begin
        held_d     = held_q;
        held_vld_d = held_vld_q;
        push       = evt_fire;
        if (evt_fire && (SUPPRESS_REPEAT != 0)) begin
            if (!evt_word[EVT_BRK]) begin
                if (key_match) begin
                    push = 1'b0;
                end else begin
                    held_d     = key;
                    held_vld_d = 1'b1;
                end
            end else if (key_match) begin
                held_vld_d = 1'b0;
            end
        end
    end

    // Sticky status: a set in the same cycle as clr_status wins. A full FIFO
    // is never empty, so evt_pop there always frees a slot.
    always_comb begin
        lost_d = lost_q && !clr_status;
        ovf_d  = ovf_q && !clr_status;
        if (push && fifo_full && !evt_pop) lost_d = 1'b1;
        if (ps_overflow)                   ovf_d  = 1'b1;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            skip_q     <= '0;
            ext_q      <= 1'b0;
            rel_q      <= 1'b0;
            held_vld_q <= 1'b0;
            lost_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            skip_q     <= skip_d;
            ext_q      <= ext_d;
            rel_q      <= rel_d;
            held_vld_q <= held_vld_d;
            lost_q     <= lost_d;
            ovf_q      <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        held_q <= held_d;
    end

    assign evt_lost = lost_q;
    assign hw_ovf   = ovf_q;

    kbd_evt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk       (clk),
        .clrn      (clrn),
        .push      (push),
        .push_data (evt_word),
        .pop       (evt_pop),
        .rd_data   (evt_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (evt_count)
    );

    assign evt_valid = !fifo_empty;

endmodule

// File: tb/tb_kbd_event_ctrl.sv
// Scoreboard bench: two controllers (repeat suppression on and off) share one
// byte source; each has its own expected-event queue.
module tb_kbd_event_ctrl;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        clrn;
    logic        en;
    logic        ps_ready;
    logic [7:0]  ps_data;
    logic        ps_overflow;
    logic        clr_status;
    logic        evt_pop, evt_pop2;

    logic        ps_nextdata_n, ps_nextdata_n2;
    logic        evt_valid, evt_valid2;
    logic [15:0] evt_data, evt_data2;
    logic [3:0]  evt_count, evt_count2;
    logic        evt_lost, evt_lost2;
    logic        hw_ovf, hw_ovf2;

    logic [15:0] exp1_q[$];
    logic [15:0] exp2_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    kbd_event_ctrl #(.DEPTH(8), .SUPPRESS_REPEAT(1)) u_dut (
        .clk(clk), .clrn(clrn), .en(en), .ps_ready(ps_ready), .ps_data(ps_data),
        .ps_overflow(ps_overflow), .ps_nextdata_n(ps_nextdata_n),
        .evt_valid(evt_valid), .evt_data(evt_data), .evt_pop(evt_pop),
        .evt_count(evt_count), .evt_lost(evt_lost), .hw_ovf(hw_ovf),
        .clr_status(clr_status)
    );

    kbd_event_ctrl #(.DEPTH(8), .SUPPRESS_REPEAT(0)) u_dut_norep (
        .clk(clk), .clrn(clrn), .en(en), .ps_ready(ps_ready), .ps_data(ps_data),
        .ps_overflow(ps_overflow), .ps_nextdata_n(ps_nextdata_n2),
        .evt_valid(evt_valid2), .evt_data(evt_data2), .evt_pop(evt_pop2),
        .evt_count(evt_count2), .evt_lost(evt_lost2), .hw_ovf(hw_ovf2),
        .clr_status(clr_status)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    endtask

    task automatic exp_both(input logic [15:0] e);
        exp1_q.push_back(e);
        exp2_q.push_back(e);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        clrn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clrn = 1'b1;
    endtask

    // Offer one byte and hold ready until the pop strobe is seen.
    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        ps_data  = b;
        ps_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ps_nextdata_n !== 1'b0 && n < 20);
        check("pop_strobe", 32'(ps_nextdata_n), 32'd0);
        check("pop_strobe_norep", 32'(ps_nextdata_n2), 32'd0);
        ps_ready = 1'b0;
    endtask

    task automatic send_seq(input bq_t s);
        foreach (s[i]) send_byte(s[i]);
    endtask

    // Pop every queued event from both controllers and compare to scoreboards.
    task automatic drain(input string tag);
        int guard = 0;
        logic [15:0] e;
        while ((evt_valid || evt_valid2) && guard < 40) begin
            if (evt_valid) begin
                e = (exp1_q.size() != 0) ? exp1_q.pop_front() : 16'hDEAD;
                check(tag, 32'(evt_data), 32'(e));
            end
            if (evt_valid2) begin
                e = (exp2_q.size() != 0) ? exp2_q.pop_front() : 16'hDEAD;
                check({tag, "_norep"}, 32'(evt_data2), 32'(e));
            end
            evt_pop  = evt_valid;
            evt_pop2 = evt_valid2;
            @(negedge clk);
            evt_pop  = 1'b0;
            evt_pop2 = 1'b0;
            guard++;
        end
        check({tag, "_missing"}, 32'(exp1_q.size()), 32'd0);
        check({tag, "_missing_norep"}, 32'(exp2_q.size()), 32'd0);
        check({tag, "_count_end"}, 32'(evt_count), 32'd0);
        check({tag, "_data_empty"}, 32'(evt_data), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t s;
        int  lows;
        clrn = 1'b0; en = 1'b1; ps_ready = 1'b0; ps_data = 8'h00;
        ps_overflow = 1'b0; clr_status = 1'b0; evt_pop = 1'b0; evt_pop2 = 1'b0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_nextdata_n", 32'(ps_nextdata_n), 32'd1);
        check("rst_evt_valid", 32'(evt_valid), 32'd0);
        check("rst_evt_data", 32'(evt_data), 32'd0);
        check("rst_evt_count", 32'(evt_count), 32'd0);
        check("rst_evt_lost", 32'(evt_lost), 32'd0);
        check("rst_hw_ovf", 32'(hw_ovf), 32'd0);
        clrn = 1'b1;

        // Single make: strobe timing and show-ahead head
        @(negedge clk);
        ps_data = 8'h1C; ps_ready = 1'b1;
        exp_both(16'h001C);
        @(negedge clk);
        check("t1_pop_low", 32'(ps_nextdata_n), 32'd0);
        check("t1_valid", 32'(evt_valid), 32'd1);
        check("t1_data", 32'(evt_data), 32'h001C);
        check("t1_count", 32'(evt_count), 32'd1);
        ps_ready = 1'b0;
        @(negedge clk);
        check("t1_pop_one_cycle", 32'(ps_nextdata_n), 32'd1);
        drain("t1_evt");

        // Extended break, then flags must be clear
        reset_dut();
        s = '{8'hE0, 8'hF0, 8'h75, 8'h1C};
        exp_both(16'hC075);
        exp_both(16'h001C);
        send_seq(s);
        drain("t2_evt");

        // Typematic repeats
        reset_dut();
        s = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
        exp1_q.push_back(16'h001C);
        exp1_q.push_back(16'h801C);
        exp1_q.push_back(16'h001C);
        exp2_q.push_back(16'h001C);
        exp2_q.push_back(16'h001C);
        exp2_q.push_back(16'h001C);
        exp2_q.push_back(16'h801C);
        exp2_q.push_back(16'h001C);
        send_seq(s);
        drain("t3_evt");

        // Fill past capacity, clear status, then push+pop while full
        reset_dut();
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_both(16'h0021 + 16'(i));
            send_byte(8'h21 + 8'(i));
        end
        @(negedge clk);
        check("t4_count_full", 32'(evt_count), 32'd8);
        check("t4_count_full_norep", 32'(evt_count2), 32'd8);
        check("t4_lost", 32'(evt_lost), 32'd1);
        check("t4_lost_norep", 32'(evt_lost2), 32'd1);
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        check("t4_lost_cleared", 32'(evt_lost), 32'd0);
        check("t4_head_before_pp", 32'(evt_data), 32'(exp1_q.pop_front()));
        check("t4_head_before_pp_norep", 32'(evt_data2), 32'(exp2_q.pop_front()));
        exp_both(16'h002A);
        ps_data = 8'h2A; ps_ready = 1'b1; evt_pop = 1'b1; evt_pop2 = 1'b1;
        @(negedge clk);
        evt_pop = 1'b0; evt_pop2 = 1'b0; ps_ready = 1'b0;
        check("t4_pp_strobe", 32'(ps_nextdata_n), 32'd0);
        check("t4_pp_count", 32'(evt_count), 32'd8);
        check("t4_pp_no_loss", 32'(evt_lost), 32'd0);
        check("t4_pp_no_loss_norep", 32'(evt_lost2), 32'd0);
        drain("t4_evt");

        // Pause sequence discarded, then en=0 blocks pops but not draining
        reset_dut();
        s = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C};
        exp_both(16'h001C);
        send_seq(s);
        @(negedge clk);
        @(negedge clk);
        en = 1'b0; ps_data = 8'h33; ps_ready = 1'b1;
        lows = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ps_nextdata_n == 1'b0) lows++;
        end
        check("t5_en0_no_pops", 32'(lows), 32'd0);
        check("t5_en0_count", 32'(evt_count), 32'd1);
        drain("t5_evt");
        ps_ready = 1'b0;
        en = 1'b1;

        // Overflow resyncs the parser and sets hw_ovf
        reset_dut();
        send_byte(8'hE0);
        @(negedge clk);
        ps_overflow = 1'b1;
        @(negedge clk);
        ps_overflow = 1'b0;
        check("t6_hw_ovf", 32'(hw_ovf), 32'd1);
        check("t6_hw_ovf_norep", 32'(hw_ovf2), 32'd1);
        check("t6_no_event", 32'(evt_valid), 32'd0);
        exp_both(16'h001C);
        send_byte(8'h1C);
        drain("t6_evt");
        ps_overflow = 1'b1; clr_status = 1'b1;
        @(negedge clk);
        ps_overflow = 1'b0; clr_status = 1'b0;
        check("t6_set_wins", 32'(hw_ovf), 32'd1);
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        check("t6_ovf_cleared", 32'(hw_ovf), 32'd0);
        check("t6_lost_clear", 32'(evt_lost), 32'd0);

        // Reset asserted mid-POP
        @(negedge clk);
        ps_data = 8'h1C; ps_ready = 1'b1;
        @(negedge clk);
        check("t7_in_pop", 32'(ps_nextdata_n), 32'd0);
        ps_ready = 1'b0;
        clrn = 1'b0;
        #1;
        check("t7_rst_nextdata_n", 32'(ps_nextdata_n), 32'd1);
        check("t7_rst_valid", 32'(evt_valid), 32'd0);
        check("t7_rst_data", 32'(evt_data), 32'd0);
        check("t7_rst_count", 32'(evt_count), 32'd0);
        check("t7_rst_ovf", 32'(hw_ovf), 32'd0);
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t7_after_valid", 32'(evt_valid), 32'd0);
        check("t7_after_count", 32'(evt_count), 32'd0);
        check("t7_after_nextdata_n", 32'(ps_nextdata_n), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
